ambiente_labirinto: RTL and testbench
=====================================

AMBIENTE_LABIRINTO -- requirements
Module: ambiente_labirinto

Interface
REQ-001 SHALL have parameter PASSOS_W, default 8, width of the successful-move counter.
REQ-002 SHALL have parameter COLISOES_W, default 4, width of the blocked-move counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 avancar  in  1  command: move one cell forward.
REQ-007 girar  in  1  command: rotate 90 degrees clockwise.
REQ-008 remover  in  1  command: clear the barrier in the front cell.
REQ-009 head  out  1  wall or grid border in the front cell.
REQ-010 left  out  1  wall, barrier or border in the left cell.
REQ-011 under  out  1  robot stands on the exit cell.
REQ-012 barrier  out  1  removable barrier in the front cell.
REQ-013 pos_x, pos_y  out  3 each  robot cell coordinates.
REQ-014 direcao  out  2  heading: N=0, E=1, S=2, W=3.
REQ-015 passos  out  PASSOS_W  successful moves, saturating.
REQ-016 colisoes  out  COLISOES_W  blocked avancar attempts, saturating.
REQ-017 chegou  out  1  high when the FSM is in CHEGOU.

Function
REQ-018 Grid SHALL be 8x8; cell index = y*8+x; N=y+1, E=x+1, S=y-1, W=x-1.
REQ-019 Front cell SHALL follow direcao; left cell SHALL follow (direcao-1) mod 4.
REQ-020 Out-of-grid front SHALL give head=1, barrier=0; out-of-grid left SHALL give left=1.
REQ-021 Sensors SHALL be combinational from registered state; a command sampled at edge k SHALL be visible on the sensors after edge k.
REQ-022 A cell with both wall and barrier set SHALL read as a wall only: head=1, barrier=0.
REQ-023 FSM states: ATIVO, CHEGOU.
REQ-024 In ATIVO with under=1, commands SHALL be ignored and the next state SHALL be CHEGOU.
REQ-025 CHEGOU SHALL be terminal until reset; commands ignored; all registers frozen.
REQ-026 Command priority SHALL be remover > girar > avancar; only the highest asserted command acts per cycle.
REQ-027 remover with barrier=1 SHALL clear that bit in the barrier register; with barrier=0 it SHALL be a no-op and SHALL NOT be counted.
REQ-028 girar SHALL set direcao to (direcao+1) mod 4 with no position change.
REQ-029 avancar with head=0 and barrier=0 SHALL move one cell and increment passos.
REQ-030 avancar with head=1 or barrier=1 SHALL leave the position unchanged and increment colisoes.
REQ-031 passos and colisoes SHALL saturate at all-ones.

Reset
REQ-032 Reset assertion SHALL immediately force: pos and direcao = package start values; barrier register = MAPA_BARREIRAS_INI; passos=0; colisoes=0; state ATIVO; chegou=0.
REQ-033 Reset mid-run SHALL restore all previously removed barriers.

Structure
REQ-034 Package ambiente_pkg SHALL hold the direction encodings, grid size, MAPA_PAREDES (64-bit), MAPA_BARREIRAS_INI (64-bit), START_X/Y/DIR, SAIDA_X/Y and the FSM state encoding.
REQ-035 Sub-module ambiente_vizinhanca SHALL compute the front and left coordinates plus their in-grid flags from pos and direcao.

Verification (bench map: start (0,0) N; wall (0,2); barrier (1,0); exit (2,0))
REQ-036 Reset release -> pos (0,0), direcao=0, head=0, left=1, barrier=0, under=0, passos=0, colisoes=0.
REQ-037 avancar 1 cycle -> pos (0,1), passos=1, head=1; avancar again -> pos (0,1), colisoes=1.
REQ-038 From (0,0): girar -> direcao=1, barrier=1; avancar -> colisoes+1, no move; remover -> barrier=0; avancar x2 -> pos (2,0), under=1; next edge chegou=1; further avancar -> passos stays 2.
REQ-039 avancar+girar+remover together with barrier=1 -> only the barrier is cleared; direcao and pos unchanged.
REQ-040 20 blocked avancar -> colisoes saturates at 15; reset asserted after a removal -> barrier at (1,0) restored, counters 0.

Source files
------------

// File: rtl/ambiente_pkg.sv
// Shared constants for the maze environment: grid geometry, headings, fixed maps,
// start/exit cells and FSM encoding.
package ambiente_pkg;
  localparam int GRID_N = 8;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Bit index = y*8+x: wall at (0,2), removable barrier at (1,0).
  localparam logic [63:0] MAPA_PAREDES       = 64'h0000_0000_0001_0000;
  localparam logic [63:0] MAPA_BARREIRAS_INI = 64'h0000_0000_0000_0002;

  localparam logic [2:0] START_X   = 3'd0;
  localparam logic [2:0] START_Y   = 3'd0;
  localparam logic [1:0] START_DIR = DIR_N;
  localparam logic [2:0] SAIDA_X   = 3'd2;
  localparam logic [2:0] SAIDA_Y   = 3'd0;

  localparam logic [0:0] ST_ATIVO  = 1'b0;
  localparam logic [0:0] ST_CHEGOU = 1'b1;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       ok;
  } celula_t;

  function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction
endpackage

// File: rtl/ambiente_labirinto_if.sv
// Command and sensor bundle between the robot controller (master) and the maze (slave).
interface ambiente_labirinto_if #(
  parameter int PASSOS_W   = 8,
  parameter int COLISOES_W = 4
);
  logic                  avancar;
  logic                  girar;
  logic                  remover;
  logic                  head;
  logic                  left;
  logic                  under;
  logic                  barrier;
  logic [2:0]            pos_x;
  logic [2:0]            pos_y;
  logic [1:0]            direcao;
  logic [PASSOS_W-1:0]   passos;
  logic [COLISOES_W-1:0] colisoes;
  logic                  chegou;

  modport master (
    output avancar, girar, remover,
    input  head, left, under, barrier, pos_x, pos_y, direcao, passos, colisoes, chegou
  );

  modport slave (
    input  avancar, girar, remover,
    output head, left, under, barrier, pos_x, pos_y, direcao, passos, colisoes, chegou
  );
endinterface

// File: rtl/ambiente_vizinhanca.sv
// Front and left neighbour coordinates of the robot, with in-grid flags.
module ambiente_vizinhanca
  import ambiente_pkg::*;
(
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  input  logic [1:0] direcao,
  output celula_t    frente,
  output celula_t    esquerda
);
  function automatic celula_t passo(input logic [2:0] x, input logic [2:0] y,
                                    input logic [1:0] d);
    celula_t c;
    c.x  = x;
    c.y  = y;
    c.ok = 1'b1;
    case (d)
      DIR_N: begin c.y = y + 3'd1; c.ok = (y != 3'd7); end
      DIR_E: begin c.x = x + 3'd1; c.ok = (x != 3'd7); end
      DIR_S: begin c.y = y - 3'd1; c.ok = (y != 3'd0); end
      default: begin c.x = x - 3'd1; c.ok = (x != 3'd0); end
    endcase
    return c;
  endfunction

  logic [1:0] dir_esq;

  // Left is one quarter-turn counter-clockwise; 2-bit wrap gives the mod 4.
  assign dir_esq  = direcao - 2'd1;
  assign frente   = passo(pos_x, pos_y, direcao);
  assign esquerda = passo(pos_x, pos_y, dir_esq);
endmodule

// File: rtl/ambiente_labirinto.sv
// 8x8 maze environment: robot position/heading state, removable barriers,
// combinational sensors and saturating move/collision counters.
module ambiente_labirinto
  import ambiente_pkg::*;
#(
  parameter int PASSOS_W   = 8,
  parameter int COLISOES_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ambiente_labirinto_if.slave  bus
);
  logic [2:0]            pos_x, pos_y;
  logic [1:0]            direcao;
  logic [63:0]           barreiras;
  logic [PASSOS_W-1:0]   passos;
  logic [COLISOES_W-1:0] colisoes;
  logic [0:0]            estado;

  celula_t     frente, esquerda;
  logic [5:0]  f_idx, l_idx;
  logic [63:0] paredes;
  logic        head, left, under, barrier;

  ambiente_vizinhanca u_viz (
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .direcao  (direcao),
    .frente   (frente),
    .esquerda (esquerda)
  );

  assign paredes = MAPA_PAREDES;
  assign f_idx   = cell_idx(frente.x, frente.y);
  assign l_idx   = cell_idx(esquerda.x, esquerda.y);

  // A wall masks any barrier bit in the same cell.
  assign head    = !frente.ok || paredes[f_idx];
  assign barrier = frente.ok && !paredes[f_idx] && barreiras[f_idx];
  assign left    = !esquerda.ok || paredes[l_idx] || barreiras[l_idx];
  assign under   = (pos_x == SAIDA_X) && (pos_y == SAIDA_Y);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_x     <= START_X;
      pos_y     <= START_Y;
      direcao   <= START_DIR;
      barreiras <= MAPA_BARREIRAS_INI;
      passos    <= '0;
      colisoes  <= '0;
      estado    <= ST_ATIVO;
    end else if (estado == ST_ATIVO) begin
      if (under) begin
        estado <= ST_CHEGOU;
      end else if (bus.remover) begin
        if (barrier) barreiras[f_idx] <= 1'b0;
      end else if (bus.girar) begin
        direcao <= direcao + 2'd1;
      end else if (bus.avancar) begin
        if (!head && !barrier) begin
          pos_x <= frente.x;
          pos_y <= frente.y;
          if (passos != '1) passos <= passos + 1'b1;
        end else if (colisoes != '1) begin
          colisoes <= colisoes + 1'b1;
        end
      end
    end
  end

  assign bus.head     = head;
  assign bus.left     = left;
  assign bus.under    = under;
  assign bus.barrier  = barrier;
  assign bus.pos_x    = pos_x;
  assign bus.pos_y    = pos_y;
  assign bus.direcao  = direcao;
  assign bus.passos   = passos;
  assign bus.colisoes = colisoes;
  assign bus.chegou   = (estado == ST_CHEGOU);
endmodule

// File: tb/tb_ambiente_labirinto.sv
// Directed bench for the maze environment on the fixed package map.
module tb_ambiente_labirinto;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  ambiente_labirinto_if #(.PASSOS_W(8), .COLISOES_W(4)) bus ();

  ambiente_labirinto #(.PASSOS_W(8), .COLISOES_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One command cycle: drive on the falling edge, sample just after the rising edge.
  task automatic cmd(input logic a, input logic g, input logic r);
    @(negedge clock);
    bus.avancar = a;
    bus.girar   = g;
    bus.remover = r;
    @(posedge clock);
    #1;
    bus.avancar = 1'b0;
    bus.girar   = 1'b0;
    bus.remover = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.avancar = 1'b0;
    bus.girar   = 1'b0;
    bus.remover = 1'b0;
    do_reset();

    chk("rst_pos_x", bus.pos_x, 0);
    chk("rst_pos_y", bus.pos_y, 0);
    chk("rst_dir", bus.direcao, 0);
    chk("rst_head", bus.head, 0);
    chk("rst_left", bus.left, 1);
    chk("rst_barrier", bus.barrier, 0);
    chk("rst_under", bus.under, 0);
    chk("rst_passos", bus.passos, 0);
    chk("rst_colisoes", bus.colisoes, 0);
    chk("rst_chegou", bus.chegou, 0);

    // North into the wall at (0,2)
    cmd(1, 0, 0);
    chk("n1_pos_y", bus.pos_y, 1);
    chk("n1_passos", bus.passos, 1);
    chk("n1_head", bus.head, 1);
    chk("n1_left", bus.left, 1);
    cmd(1, 0, 0);
    chk("n2_pos_y", bus.pos_y, 1);
    chk("n2_colisoes", bus.colisoes, 1);
    chk("n2_passos", bus.passos, 1);

    // East through the barrier to the exit
    do_reset();
    cmd(0, 1, 0);
    chk("e_dir", bus.direcao, 1);
    chk("e_barrier", bus.barrier, 1);
    chk("e_head", bus.head, 0);
    chk("e_left", bus.left, 0);
    cmd(1, 0, 0);
    chk("e_blk_col", bus.colisoes, 1);
    chk("e_blk_x", bus.pos_x, 0);
    cmd(0, 0, 1);
    chk("e_rem_barrier", bus.barrier, 0);
    cmd(1, 0, 0);
    chk("e_mv1_x", bus.pos_x, 1);
    cmd(1, 0, 0);
    chk("e_mv2_x", bus.pos_x, 2);
    chk("e_under", bus.under, 1);
    chk("e_chegou_pre", bus.chegou, 0);
    chk("e_passos", bus.passos, 2);
    cmd(1, 0, 0);
    chk("e_chegou", bus.chegou, 1);
    chk("e_frz_passos", bus.passos, 2);
    chk("e_frz_x", bus.pos_x, 2);
    cmd(1, 1, 0);
    chk("e_frz_dir", bus.direcao, 1);
    chk("e_frz_passos2", bus.passos, 2);

    // Priority: remover with no barrier is a no-op that still blocks girar
    do_reset();
    cmd(0, 1, 1);
    chk("p_noop_dir", bus.direcao, 0);
    cmd(0, 1, 0);
    cmd(1, 1, 1);
    chk("p_all_barrier", bus.barrier, 0);
    chk("p_all_dir", bus.direcao, 1);
    chk("p_all_x", bus.pos_x, 0);
    chk("p_all_passos", bus.passos, 0);
    chk("p_all_col", bus.colisoes, 0);
    cmd(0, 1, 0);
    chk("s_dir", bus.direcao, 2);
    chk("s_head", bus.head, 1);
    chk("s_barrier", bus.barrier, 0);
    cmd(0, 1, 0);
    chk("w_dir", bus.direcao, 3);
    chk("w_head", bus.head, 1);
    cmd(0, 1, 0);
    chk("wrap_dir", bus.direcao, 0);

    // Collision saturation, then asynchronous reset restores the barrier
    do_reset();
    cmd(0, 1, 0);
    for (int i = 0; i < 20; i++) cmd(1, 0, 0);
    chk("sat_colisoes", bus.colisoes, 15);
    chk("sat_x", bus.pos_x, 0);
    cmd(0, 0, 1);
    chk("sat_rem", bus.barrier, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("ar_colisoes", bus.colisoes, 0);
    chk("ar_dir", bus.direcao, 0);
    chk("ar_passos", bus.passos, 0);
    @(negedge clock);
    reset = 1'b1;
    cmd(0, 1, 0);
    chk("ar_barrier", bus.barrier, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
